cdf_builder: RTL and testbench

Builds the cumulative distribution table the output pipeline consumes. After `start`, it streams the 256-bin histogram out of the M1 scratchpad and computes a saturating running prefix sum. It writes the CDF into the M2 scratchpad and derives `CdfMin` and `divisor` for the equalization stages. It is the writer side of the M2SP CDF table that the output pipeline's CDF fetch stage reads.

---
 rtl/cdf_pkg.sv | 9 +
 rtl/cdf_lane_adder.sv | 31 +++
 rtl/cdf_builder.sv | 103 ++++++++++
 tb/tb_cdf_builder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cdf_pkg.sv
// cdf_pkg: shared CDF table layout constants and builder state encoding; no ports
package cdf_pkg;
  localparam int CDF_WORDS = 64;
  localparam int BINS_PER_WORD = 4;
  localparam int LANE_W = 32;
  localparam int CNT_W = 20;
  localparam logic [19:0] SAT_MAX = 20'hFFFFF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;
endpackage

// File: rtl/cdf_lane_adder.sv
// cdf_lane_adder: saturating 4-lane prefix sum; in cin_i (carry sum), cnt_i (packed counts); out cdf_o (packed prefixes), cout_o, first_idx_o/first_val_o (first nonzero lane, value 0 if none)
module cdf_lane_adder import cdf_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic [W-1:0]               cin_i,
  input  logic [BINS_PER_WORD*W-1:0] cnt_i,
  output logic [BINS_PER_WORD*W-1:0] cdf_o,
  output logic [W-1:0]               cout_o,
  output logic [1:0]                 first_idx_o,
  output logic [W-1:0]               first_val_o
);
  logic [W:0]   s;
  logic [W-1:0] run;
  always_comb begin
    cdf_o = '0;
    first_idx_o = '0;
    first_val_o = '0;
    s = '0;
    run = cin_i;
    for (int i = 0; i < BINS_PER_WORD; i++) begin
      s = {1'b0, run} + {1'b0, cnt_i[i*W +: W]};
      run = s[W] ? '1 : s[W-1:0];
      cdf_o[i*W +: W] = run;
      if (first_val_o == '0 && run != '0) begin
        first_idx_o = 2'(i);
        first_val_o = run;
      end
    end
    cout_o = run;
  end
endmodule

// File: rtl/cdf_builder.sv
// cdf_builder: streams histogram from M1SP, writes saturating CDF to M2SP; in clock/reset_n/start/M1SP_ReadBus; out M1SP_ReadAddress, M2SP_Write{Bus,Address,Enable}, CdfMin, divisor, done
module cdf_builder import cdf_pkg::*; #(
  parameter int CNT_W = 20,
  parameter int WORDS = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [127:0]     M1SP_ReadBus,
  output logic [15:0]      M1SP_ReadAddress,
  output logic [127:0]     M2SP_WriteBus,
  output logic [15:0]      M2SP_WriteAddress,
  output logic             M2SP_WriteEnable,
  output logic [CNT_W-1:0] CdfMin,
  output logic [CNT_W-1:0] divisor,
  output logic             done
);
  localparam int AW = $clog2(WORDS);
  localparam int PAD_W = LANE_W - CNT_W;
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, rd_idx_q, wr_addr_q;
  logic vld_q, we_q, found_q;
  logic [CNT_W-1:0] sum_q, min_q, div_q, carry, first_val, diff;
  logic [1:0] first_idx;
  logic [BINS_PER_WORD*CNT_W-1:0] cnt, cdf;
  logic [BINS_PER_WORD*PAD_W-1:0] unused_pad;
  logic [127:0] wbus_q, wbus_d;
  always_comb begin
    cnt = '0;
    unused_pad = '0;
    wbus_d = '0;
    for (int i = 0; i < BINS_PER_WORD; i++) begin
      cnt[i*CNT_W +: CNT_W] = M1SP_ReadBus[i*LANE_W +: CNT_W];
      unused_pad[i*PAD_W +: PAD_W] = M1SP_ReadBus[i*LANE_W+CNT_W +: PAD_W];
      wbus_d[i*LANE_W +: CNT_W] = cdf[i*CNT_W +: CNT_W];
    end
  end
  cdf_lane_adder #(.W(CNT_W)) u_lanes (
    .cin_i      (sum_q),
    .cnt_i      (cnt),
    .cdf_o      (cdf),
    .cout_o     (carry),
    .first_idx_o(first_idx),
    .first_val_o(first_val)
  );
  assign diff = sum_q - min_q;
  always_comb begin
    state_d = state_q;
    done = 1'b0;
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && addr_q == LAST) ? DRAIN :
              (state_q == DRAIN && we_q && wr_addr_q == LAST) ? FIN :
              (state_q == FIN) ? IDLE : state_q;
    done = state_q == FIN;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rd_idx_q <= '0;
      wr_addr_q <= '0;
      vld_q <= 1'b0;
      we_q <= 1'b0;
      found_q <= 1'b0;
      sum_q <= '0;
      min_q <= '0;
      div_q <= '0;
      wbus_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= state_q == RUN;
      rd_idx_q <= addr_q;
      we_q <= vld_q;
      if (vld_q) begin
        wbus_q <= wbus_d;
        wr_addr_q <= rd_idx_q;
        sum_q <= carry;
        if (!found_q && first_val != '0) begin
          found_q <= 1'b1;
          min_q <= cdf[first_idx*CNT_W +: CNT_W];
        end
      end
      if (state_q == IDLE && start) begin
        addr_q <= '0;
        sum_q <= '0;
        min_q <= '0;
        found_q <= 1'b0;
      end else if (state_q == RUN && addr_q != LAST) begin
        addr_q <= addr_q + 1'b1;
      end else if (state_q == FIN) begin
        addr_q <= '0;
      end
      if (state_q == DRAIN && state_d == FIN) div_q <= (diff == '0) ? CNT_W'(1) : diff;
    end
  end
  assign M1SP_ReadAddress = 16'(addr_q);
  assign M2SP_WriteBus = wbus_q;
  assign M2SP_WriteAddress = 16'(wr_addr_q);
  assign M2SP_WriteEnable = we_q;
  assign CdfMin = min_q;
  assign divisor = div_q;
endmodule

// File: tb/tb_cdf_builder.sv
// tb_cdf_builder: randomized scoreboard bench for cdf_builder against a prefix-sum reference model
module tb_cdf_builder;
  logic clock = 1'b0;
  logic reset_n, start;
  logic [127:0] M1SP_ReadBus;
  logic [15:0] M1SP_ReadAddress, M2SP_WriteAddress;
  logic [127:0] M2SP_WriteBus;
  logic M2SP_WriteEnable, done;
  logic [19:0] CdfMin, divisor;
  typedef struct packed {logic [15:0] addr; logic [127:0] data; logic [31:0] cyc;} wexp_t;
  typedef struct packed {logic [19:0] mn; logic [19:0] dv; logic [31:0] cyc;} dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];
  logic [19:0] hist[256];
  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  bit active = 0;
  cdf_builder dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .M1SP_ReadBus(M1SP_ReadBus), .M1SP_ReadAddress(M1SP_ReadAddress),
    .M2SP_WriteBus(M2SP_WriteBus), .M2SP_WriteAddress(M2SP_WriteAddress),
    .M2SP_WriteEnable(M2SP_WriteEnable), .CdfMin(CdfMin), .divisor(divisor), .done(done)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    for (int l = 0; l < 4; l++)
      M1SP_ReadBus[32*l +: 32] <= {12'($urandom), hist[4*int'(M1SP_ReadAddress[5:0]) + l]};
  end
  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  always @(negedge clock) if (reset_n) begin
    if (M2SP_WriteEnable) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got address %0d expected no write (cycle %0d)", M2SP_WriteAddress, cyc);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_addr", 128'(M2SP_WriteAddress), 128'(e.addr));
        chk("wr_data", M2SP_WriteBus, e.data);
        chk("wr_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        dexp_t d;
        d = dq.pop_front();
        chk("cdfmin", 128'(CdfMin), 128'(d.mn));
        chk("divisor", 128'(divisor), 128'(d.dv));
        chk("done_cycle", 128'(cyc), 128'(d.cyc));
      end
    end
    if (active && cyc - start_cyc <= 66)
      chk("rd_addr", 128'(M1SP_ReadAddress), 128'((cyc - start_cyc < 63) ? cyc - start_cyc : 63));
  end
  task automatic fill(input int mode);
    for (int b = 0; b < 256; b++) begin
      case (mode)
        0: hist[b] = 20'd4096;
        1: hist[b] = 20'd16;
        2: hist[b] = (b == 10) ? 20'd7 : (b == 200) ? 20'd993 : 20'd0;
        3: hist[b] = 20'd0;
        4: hist[b] = (b == 255) ? 20'd50 : 20'd0;
        5: hist[b] = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(0, 600));
        default: hist[b] = ($urandom_range(0, 1) == 0) ? 20'd0 : 20'($urandom_range(0, 20'h3FFF));
      endcase
    end
  endtask
  task automatic kick();
    longint s;
    logic [19:0] c[256];
    logic [19:0] mn;
    logic [127:0] w;
    dexp_t d;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    active = 1;
    s = 0;
    mn = 0;
    for (int b = 0; b < 256; b++) begin
      s += hist[b];
      c[b] = (s > 64'hFFFFF) ? 20'hFFFFF : 20'(s);
      if (mn == 0) mn = c[b];
    end
    for (int k = 0; k < 64; k++) begin
      w = '0;
      for (int l = 0; l < 4; l++) w[32*l +: 20] = c[4*k + l];
      wq.push_back({16'(k), w, 32'(start_cyc + k + 2)});
    end
    d.mn = mn;
    d.dv = (c[255] - mn == 0) ? 20'd1 : c[255] - mn;
    d.cyc = 32'(start_cyc + 66);
    dq.push_back(d);
  endtask
  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_rdaddr"}, 128'(M1SP_ReadAddress), 128'd0);
    chk({nm, "_wbus"}, M2SP_WriteBus, 128'd0);
    chk({nm, "_waddr"}, 128'(M2SP_WriteAddress), 128'd0);
    chk({nm, "_we"}, 128'(M2SP_WriteEnable), 128'd0);
    chk({nm, "_cdfmin"}, 128'(CdfMin), 128'd0);
    chk({nm, "_divisor"}, 128'(divisor), 128'd0);
    chk({nm, "_done"}, 128'(done), 128'd0);
  endtask
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    fill(3);
    repeat (3) @(negedge clock);
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    for (int m = 0; m < 7; m++) begin
      fill(m);
      kick();
      repeat (70) @(posedge clock);
    end
    fill(5);
    kick();
    repeat (20) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (50) @(posedge clock);
    for (int r = 0; r < 3; r++) begin
      fill(r == 1 ? 6 : 5);
      kick();
      repeat (67) @(posedge clock);
      #1;
    end
    repeat (70) @(posedge clock);
    fill(1);
    kick();
    repeat (30) @(posedge clock);
    #1;
    reset_n = 1'b0;
    active = 0;
    wq.delete();
    dq.delete();
    #1;
    chk_zero_outputs("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (80) @(negedge clock);
    fill(2);
    kick();
    repeat (70) @(posedge clock);
    repeat (5) @(negedge clock);
    chk("writes_left", 128'(wq.size()), 128'd0);
    chk("done_left", 128'(dq.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
